param_ram_ctrl: RTL and testbench
=================================

Name: param_ram_ctrl

Overview:
Parametrised single-port synchronous RAM with a valid/ready request interface, separate read/write data buses (no tri-state), byte-enable writes and configurable read latency. It also has a hardware fill engine that writes FILL_VALUE to every location after reset or on command, so no simulation-only initial block is needed. It sits behind the timing/sequencer logic as general sample/pattern storage.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of 8.
ADDR_W, 15, address width.
DEPTH, 32768, number of words; 1 <= DEPTH <= 2**ADDR_W.
READ_LATENCY, 1, cycles from accepted read to rsp_valid; legal values are 1 or 2.
FILL_VALUE, 0, word written to every location during fill.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  request accepted when req_valid && req_ready.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data.
req_be  input  DATA_W/8  byte enables for writes; ignored on reads.
rsp_valid  output  1  one-cycle pulse carrying read data; there is no backpressure.
rsp_rdata  output  DATA_W  read data; held until the next rsp_valid.
rsp_err  output  1  qualified by rsp_valid; the read hit an out-of-range address (or a parity error when the optional feature is enabled).
fill_req  input  1  pulse that requests a re-fill of the whole array.
fill_busy  output  1  high while draining or filling.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, fill_busy=1. The FSM enters S_FILL with fill address 0.
- The FSM has three states: S_FILL, S_RUN and S_DRAIN.
- S_FILL:
  - Writes FILL_VALUE to the fill address every cycle, with all bytes enabled.
  - The address counter increments each cycle; after writing DEPTH-1 the FSM goes to S_RUN.
  - A full fill takes exactly DEPTH cycles. req_ready=0 and fill_busy=1 throughout.
- S_RUN:
  - req_ready=1 and fill_busy=0. One request is accepted per cycle.
  - When fill_req=1 the FSM goes to S_DRAIN. req_ready drops in the same cycle, so no request is accepted in the fill_req cycle.
- S_DRAIN:
  - req_ready=0 and fill_busy=1.
  - Waits until the read pipeline is empty (no rsp_valid outstanding), then goes to S_FILL with fill address 0.
  - Every outstanding read completes with pre-fill data.
- fill_req is ignored in S_FILL and S_DRAIN.
- Write: an accepted write updates only the bytes whose req_be bit is 1, at the end of the accept cycle. req_be=0 is a legal no-op.
- Read:
  - An accepted read at cycle T gives rsp_valid at T+READ_LATENCY.
  - Back-to-back reads produce back-to-back responses, in order.
- Read-after-write: a read accepted at cycle T+1 to an address written at cycle T returns the new data.
- Out-of-range address (addr >= DEPTH):
  - A write is dropped and memory is unchanged.
  - A read still responds with the normal latency, rsp_rdata=0 and rsp_err=1.
- Reset asserted mid-operation (including mid-fill):
  - The pipeline is flushed and the FSM restarts S_FILL from address 0.
  - Memory contents are undefined until that fill completes.
- The fill counter is ADDR_W+1 bits wide so that DEPTH = 2**ADDR_W terminates correctly.

Optional Feature:
Macro PARAM_RAM_PARITY_EN.
- Defined:
  - Each byte stores one extra even-parity bit, computed on write and on fill.
  - A read recomputes parity; any byte mismatch sets rsp_err=1 with the data passed through unchanged.
  - An extra input err_inject (1 bit) inverts the stored parity of every enabled byte on writes accepted while it is high.
- Undefined: no parity storage, no err_inject port, and rsp_err reports out-of-range only.

Decomposition:
- Package param_ram_pkg holds:
  - the state enum (S_FILL, S_RUN, S_DRAIN);
  - the localparam BE_W = DATA_W/8;
  - the parity-width helper function.
- Sub-module param_ram_array holds the pure storage: a registered-read array with per-byte write enables, and parity bits when the macro is set.
- param_ram_ctrl holds the FSM, the fill counter, the range check and the latency pipeline.

Test Plan:
- Reset with DEPTH=16: fill_busy high for exactly 16 cycles then low; reads of addresses 0-15 all return 0x00 with rsp_err=0.
- With DATA_W=32: write 0xAABBCCDD to addr 3 with be=4'b1111, then write 0x11223344 with be=4'b0101; reading addr 3 returns 0xAA22CC44.
- READ_LATENCY=2: reads of addresses 0,1,2 in consecutive cycles give rsp_valid at T+2, T+3, T+4 with the matching data; a read issued the cycle after a write returns the new data.
- DEPTH=12, ADDR_W=4: a write to addr 13 leaves memory unchanged; a read of addr 13 gives rsp_rdata=0 and rsp_err=1.
- fill_req issued the cycle after two reads: both responses return pre-fill data, then fill_busy is high for DEPTH cycles and all locations read FILL_VALUE. Asserting rst mid-fill restarts the full DEPTH-cycle fill.
- PARAM_RAM_PARITY_EN: write 0x5A with err_inject=1, then read gives rsp_err=1 and rsp_rdata=0x5A; rewrite with err_inject=0, then read gives rsp_err=0.

Source files
------------

// File: rtl/param_ram_pkg.sv
// Shared types and sizing helpers for the param_ram_ctrl block.
// Parity storage is compiled in only when PARAM_RAM_PARITY_EN is defined.
package param_ram_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Number of byte lanes (and byte-enable bits) for a data word.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // Total parity bits stored per word: one per byte when parity is built in.
  function automatic int par_width(input int data_w);
`ifdef PARAM_RAM_PARITY_EN
    return data_w / 8;
`else
    return 0;
`endif
  endfunction

endpackage

// File: rtl/param_ram_array.sv
// Byte-lane storage with registered read and per-byte write enables.
// With PARAM_RAM_PARITY_EN each lane also keeps an even-parity bit.
module param_ram_array
  import param_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32768,
  parameter int AW     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
`ifdef PARAM_RAM_PARITY_EN
  input  logic                  i_inject,
  output logic                  o_par_err,
`endif
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int BE_W   = be_width(DATA_W);
  localparam int LANE_W = 8 + par_width(DATA_W) / BE_W;

`ifdef PARAM_RAM_PARITY_EN
  logic [BE_W-1:0] w_lane_err;
  assign o_par_err = |w_lane_err;
`endif

  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    logic [LANE_W-1:0] w_wr_lane;
    logic [LANE_W-1:0] r_mem [DEPTH];
    logic [LANE_W-1:0] r_rd;

`ifdef PARAM_RAM_PARITY_EN
    assign w_wr_lane = {(^i_wdata[8*b +: 8]) ^ i_inject, i_wdata[8*b +: 8]};
`else
    assign w_wr_lane = i_wdata[8*b +: 8];
`endif

    // NOTE: the storage array has no reset; the fill engine initialises it,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
      if (i_we && i_be[b]) r_mem[i_addr] <= w_wr_lane;
    end

    // Read register only moves on a read, so the last read word is held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_rd <= '0;
      else if (i_re) r_rd <= r_mem[i_addr];
    end

    assign o_rdata[8*b +: 8] = r_rd[7:0];
`ifdef PARAM_RAM_PARITY_EN
    assign w_lane_err[b] = ^r_rd;
`endif
  end

endmodule

// File: rtl/param_ram_ctrl.sv
// Single-port RAM controller: fill/run/drain FSM, range check, read pipeline.
// Define PARAM_RAM_PARITY_EN to add per-byte parity and the err_inject input.
module param_ram_ctrl
  import param_ram_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 15,
  parameter int                DEPTH        = 32768,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  input  logic                  fill_req,
`ifdef PARAM_RAM_PARITY_EN
  input  logic                  err_inject,
`endif
  output logic                  fill_busy
);

  localparam int BE_W = be_width(DATA_W);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic [ADDR_W:0]   r_fill_addr;
  logic              r_req_ready;
  logic              r_fill_busy;
  logic              r_vld1;
  logic              r_oor1;

  logic              w_accept;
  logic              w_in_range;
  logic              w_rd_acc;
  logic              w_fill_we;
  logic              w_arr_we;
  logic [BE_W-1:0]   w_arr_be;
  logic [AW-1:0]     w_arr_addr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;
  logic [DATA_W-1:0] w_s1_data;
  logic              w_s1_err;
  logic              w_pipe_busy;

  // NOTE: ready is registered but gated combinationally by fill_req so that
  // nothing is accepted in the cycle the re-fill is requested.
  assign req_ready = r_req_ready & ~fill_req;
  assign fill_busy = r_fill_busy;

  assign w_accept   = req_valid & req_ready;
  assign w_in_range = ({1'b0, req_addr} < DEPTH_C);
  assign w_rd_acc   = w_accept & ~req_we;
  assign w_fill_we  = (r_state == S_FILL);

  assign w_arr_we    = w_fill_we | (w_accept & req_we & w_in_range);
  assign w_arr_be    = w_fill_we ? '1 : req_be;
  assign w_arr_addr  = w_fill_we ? r_fill_addr[AW-1:0] : req_addr[AW-1:0];
  assign w_arr_wdata = w_fill_we ? FILL_VALUE : req_wdata;

`ifdef PARAM_RAM_PARITY_EN
  logic w_par_err;
`endif

  param_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_arr_we),
    .i_be     (w_arr_be),
    .i_addr   (w_arr_addr),
    .i_wdata  (w_arr_wdata),
    .i_re     (w_rd_acc & w_in_range),
`ifdef PARAM_RAM_PARITY_EN
    .i_inject (err_inject & ~w_fill_we),
    .o_par_err(w_par_err),
`endif
    .o_rdata  (w_arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_fill_addr <= '0;
      r_req_ready <= 1'b0;
      r_fill_busy <= 1'b1;
    end else begin
      case (r_state)
        S_FILL: begin
          r_fill_addr <= r_fill_addr + 1'b1;
          if (r_fill_addr + 1'b1 == DEPTH_C) begin
            r_state     <= S_RUN;
            r_req_ready <= 1'b1;
            r_fill_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (fill_req) begin
            r_state     <= S_DRAIN;
            r_req_ready <= 1'b0;
            r_fill_busy <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!w_pipe_busy) begin
            r_state     <= S_FILL;
            r_fill_addr <= '0;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Stage 1 mirrors the array read register; the out-of-range flag is held
  // alongside it so data and error stay paired until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld1 <= 1'b0;
      r_oor1 <= 1'b0;
    end else begin
      r_vld1 <= w_rd_acc;
      if (w_rd_acc) r_oor1 <= ~w_in_range;
    end
  end

  assign w_s1_data = r_oor1 ? '0 : w_arr_rdata;
`ifdef PARAM_RAM_PARITY_EN
  assign w_s1_err  = r_oor1 | w_par_err;
`else
  assign w_s1_err  = r_oor1;
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic              r_vld2;
    logic [DATA_W-1:0] r_rdata2;
    logic              r_err2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld2   <= 1'b0;
        r_rdata2 <= '0;
        r_err2   <= 1'b0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_rdata2 <= w_s1_data;
          r_err2   <= w_s1_err;
        end
      end
    end

    assign rsp_valid   = r_vld2;
    assign rsp_rdata   = r_rdata2;
    assign rsp_err     = r_err2;
    assign w_pipe_busy = r_vld1 | r_vld2;
  end else begin : g_lat1
    assign rsp_valid   = r_vld1;
    assign rsp_rdata   = w_s1_data;
    assign rsp_err     = w_s1_err;
    assign w_pipe_busy = r_vld1;
  end

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Scoreboard bench: two controllers (read latency 1 and 2) share one stimulus
// stream; per-instance monitors pop expected responses and check data, error and arrival edge.
module tb_param_ram_ctrl;

  localparam logic [31:0] FILL  = 32'hC3C3_5A5A;
  localparam int          DEPTH = 12;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, fill_req;
  logic [3:0]  req_addr, req_be;
  logic [31:0] req_wdata;
`ifdef PARAM_RAM_PARITY_EN
  logic        err_inject;
`endif
  logic [1:0]        rdy, rv, re, fb;
  logic [1:0][31:0]  rd;

  item_t q0[$];
  item_t q1[$];
  item_t mon_it;
  int    edge_cnt = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    c0, c1;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  param_ram_ctrl #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH), .READ_LATENCY(1), .FILL_VALUE(FILL)
  ) u_dut_rl1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]), .fill_req(fill_req),
`ifdef PARAM_RAM_PARITY_EN
    .err_inject(err_inject),
`endif
    .fill_busy(fb[0])
  );

  param_ram_ctrl #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH), .READ_LATENCY(2), .FILL_VALUE(FILL)
  ) u_dut_rl2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]), .fill_req(fill_req),
`ifdef PARAM_RAM_PARITY_EN
    .err_inject(err_inject),
`endif
    .fill_busy(fb[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic cmp_rsp(input int inst, input item_t it, input logic [31:0] d, input logic e);
    check($sformatf("rl%0d %s data", inst + 1, it.name), d, it.data);
    check($sformatf("rl%0d %s err", inst + 1, it.name), 32'(e), 32'(it.err));
    check($sformatf("rl%0d %s edge", inst + 1, it.name), 32'(edge_cnt), 32'(it.due));
  endtask

  // Monitors: responses are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rv[0]) begin
        if (q0.size() == 0) check("rl1 unexpected rsp_valid", 32'(rv[0]), 32'd0);
        else begin mon_it = q0.pop_front(); cmp_rsp(0, mon_it, rd[0], re[0]); end
      end else if (q0.size() != 0 && q0[0].due < edge_cnt) begin
        mon_it = q0.pop_front();
        check({"rl1 missing rsp ", mon_it.name}, 32'(rv[0]), 32'd1);
      end
      if (rv[1]) begin
        if (q1.size() == 0) check("rl2 unexpected rsp_valid", 32'(rv[1]), 32'd0);
        else begin mon_it = q1.pop_front(); cmp_rsp(1, mon_it, rd[1], re[1]); end
      end else if (q1.size() != 0 && q1[0].due < edge_cnt) begin
        mon_it = q1.pop_front();
        check({"rl2 missing rsp ", mon_it.name}, 32'(rv[1]), 32'd1);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int w = 0;
    ok = 1'b1;
    req_valid = 1'b0;
    while (!(rdy[0] && rdy[1])) begin
      if (w == 200) begin
        check("req_ready timeout", 32'(rdy), 32'h3);
        ok = 1'b0;
        return;
      end
      w++;
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic inj);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
`ifdef PARAM_RAM_PARITY_EN
    err_inject = inj;
`else
    if (inj) req_be = be;
`endif
  endtask

  task automatic rd_req(input logic [3:0] a, input logic [31:0] exp_d, input logic exp_e,
                        input string name);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_be = 4'h0;
`ifdef PARAM_RAM_PARITY_EN
    err_inject = 1'b0;
`endif
    q0.push_back('{data: exp_d, err: exp_e, due: edge_cnt + 1, name: name});
    q1.push_back('{data: exp_d, err: exp_e, due: edge_cnt + 2, name: name});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Counts falling edges with fill_busy high, starting at the current one.
  task automatic count_fill(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 200; k++) begin
      if (!fb[0] && !fb[1]) break;
      if (fb[0]) n0++;
      if (fb[1]) n1++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s rl%0d req_ready", tag, i + 1), 32'(rdy[i]), 32'd0);
      check($sformatf("%s rl%0d rsp_valid", tag, i + 1), 32'(rv[i]), 32'd0);
      check($sformatf("%s rl%0d rsp_rdata", tag, i + 1), rd[i], 32'd0);
      check($sformatf("%s rl%0d rsp_err", tag, i + 1), 32'(re[i]), 32'd0);
      check($sformatf("%s rl%0d fill_busy", tag, i + 1), 32'(fb[i]), 32'd1);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; fill_req = 1'b0;
`ifdef PARAM_RAM_PARITY_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    rst = 1'b0;
    count_fill(c0, c1);
    check("rl1 fill cycles after reset", 32'(c0), 32'd12);
    check("rl2 fill cycles after reset", 32'(c1), 32'd12);
    for (int a = 0; a < DEPTH; a++) rd_req(4'(a), FILL, 1'b0, $sformatf("init fill a%0d", a));

    // Byte-enable merge and no-op write
    wr(4'd3, 32'hAABB_CCDD, 4'b1111, 1'b0);
    wr(4'd3, 32'h1122_3344, 4'b0101, 1'b0);
    wr(4'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd_req(4'd3, 32'hAA22_CC44, 1'b0, "be merge a3");

    // Back-to-back reads and read-after-write
    wr(4'd0, 32'h0000_0010, 4'hF, 1'b0);
    wr(4'd1, 32'h0000_0021, 4'hF, 1'b0);
    wr(4'd2, 32'h0000_0032, 4'hF, 1'b0);
    rd_req(4'd0, 32'h0000_0010, 1'b0, "b2b a0");
    rd_req(4'd1, 32'h0000_0021, 1'b0, "b2b a1");
    rd_req(4'd2, 32'h0000_0032, 1'b0, "b2b a2");
    wr(4'd5, 32'h1234_5678, 4'hF, 1'b0);
    rd_req(4'd5, 32'h1234_5678, 1'b0, "raw a5");

    // Range boundary: 11 is the last word, 12 and 13 are out of range
    wr(4'd11, 32'h0BAD_CAFE, 4'hF, 1'b0);
    wr(4'd12, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wr(4'd13, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd_req(4'd11, 32'h0BAD_CAFE, 1'b0, "last a11");
    rd_req(4'd12, 32'h0000_0000, 1'b1, "oor a12");
    rd_req(4'd13, 32'h0000_0000, 1'b1, "oor a13");
    rd_req(4'd3, 32'hAA22_CC44, 1'b0, "after oor a3");
    rd_req(4'd0, 32'h0000_0010, 1'b0, "after oor a0");
    idle(1);
    wait_drain();

    // Re-fill requested the cycle after two reads; a read offered then is refused
    rd_req(4'd3, 32'hAA22_CC44, 1'b0, "prefill a3");
    rd_req(4'd5, 32'h1234_5678, 1'b0, "prefill a5");
    @(negedge clk);
    fill_req = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    #1;
    check("rl1 ready in fill_req cycle", 32'(rdy[0]), 32'd0);
    check("rl2 ready in fill_req cycle", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    fill_req = 1'b0; req_valid = 1'b0;
    count_fill(c0, c1);
    check("rl1 busy cycles drain+fill", 32'(c0), 32'd13);
    check("rl2 busy cycles drain+fill", 32'(c1), 32'd14);
    for (int a = 0; a < DEPTH; a++) rd_req(4'(a), FILL, 1'b0, $sformatf("refill a%0d", a));
    idle(1);
    wait_drain();

    // Reset in the middle of a fill restarts the full fill
    wr(4'd7, 32'h7777_7777, 4'hF, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid-fill reset");
    rst = 1'b0;
    count_fill(c0, c1);
    check("rl1 fill cycles after mid reset", 32'(c0), 32'd12);
    check("rl2 fill cycles after mid reset", 32'(c1), 32'd12);
    for (int a = 0; a < DEPTH; a++) rd_req(4'(a), FILL, 1'b0, $sformatf("post-reset a%0d", a));

`ifdef PARAM_RAM_PARITY_EN
    wr(4'd0, 32'h0000_005A, 4'hF, 1'b1);
    rd_req(4'd0, 32'h0000_005A, 1'b1, "parity injected");
    wr(4'd0, 32'h0000_005A, 4'hF, 1'b0);
    rd_req(4'd0, 32'h0000_005A, 1'b0, "parity clean");
`endif

    idle(1);
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
